// File: rtl/led_pkg.sv
// Shared types and constants for the LED sweep monitor.
// Pure definitions: no logic, no latency, no flow control.
package led_pkg;

   typedef enum logic {
      ACQUIRE = 1'b0,
      TRACK   = 1'b1
   } mon_state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;
   localparam int   LED_N    = 8;

endpackage

// File: rtl/onehot_decode.sv
// Combinational one-hot classifier: {valid (exactly one bit), zero, index}.
// Zero latency; no flow control.
module onehot_decode #(
   parameter int N  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  vec,
   output logic          valid,
   output logic          zero,
   output logic [IW-1:0] index
);

   localparam logic [N-1:0] ONE = N'(1);

   always_comb begin
      zero  = (vec == '0);
      // clearing the lowest set bit leaves nothing only for a single-bit vector
      valid = !zero && ((vec & (vec - ONE)) == '0);
      index = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) index = IW'(i);
      end
   end

endmodule

// File: rtl/led_sweep_monitor.sv
// Checks a bouncing one-hot LED bus: tracks position/direction, flags bad steps, counts bounces/errors.
// Registered outputs one cycle after led_in is sampled; observe-only, never stalls the source.
module led_sweep_monitor
   import led_pkg::*;
#(
   parameter int N  = LED_N,
   parameter int CW = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         led_in,
   input  logic                 clear,
   output logic [$clog2(N)-1:0] pos,
   output logic                 pos_valid,
   output logic                 dir,
   output logic                 locked,
   output logic                 step_err,
   output logic [CW-1:0]        bounce_count,
   output logic [CW-1:0]        err_count
);

   localparam int            PW      = $clog2(N);
   localparam logic [PW:0]   STEP    = 1;
   localparam logic [PW-1:0] TOP_IDX = PW'(N - 1);
   localparam logic [CW-1:0] CNT_ONE = 1;

   mon_state_t    state_q, state_d;
   logic [N-1:0]  last_q, last_d;
   logic [PW-1:0] pos_q, pos_d;
   logic          pos_valid_q, pos_valid_d;
   logic          dir_q, dir_d;
   logic          step_err_q, step_err_d;
   logic [CW-1:0] bounce_q, err_q;
   logic          bounce_inc, err_inc;
   logic          accept, acc_dir;

   logic          dec_valid, dec_zero;
   logic [PW-1:0] dec_idx;
   logic [PW:0]   pos_ext, idx_ext, exp_ext;

   onehot_decode #(.N(N), .IW(PW)) u_dec (
      .vec   (led_in),
      .valid (dec_valid),
      .zero  (dec_zero),
      .index (dec_idx)
   );

   // one extra bit so pos+/-1 at the ends never aliases onto a real index
   assign pos_ext = {1'b0, pos_q};
   assign idx_ext = {1'b0, dec_idx};
   assign exp_ext = (dir_q == DIR_UP) ? pos_ext + STEP : pos_ext - STEP;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      pos_d       = pos_q;
      pos_valid_d = pos_valid_q;
      dir_d       = dir_q;
      step_err_d  = 1'b0;
      bounce_inc  = 1'b0;
      err_inc     = 1'b0;
      accept      = 1'b0;
      acc_dir     = dir_q;

      if (led_in != last_q) begin
         last_d = led_in;
         unique case (state_q)
            ACQUIRE: begin
               if (dec_zero) begin
                  pos_valid_d = pos_valid_q;
               end else if (!dec_valid) begin
                  pos_valid_d = 1'b0;
               end else if (pos_valid_q &&
                            ((idx_ext == pos_ext + STEP) || (pos_ext == idx_ext + STEP))) begin
                  accept  = 1'b1;
                  acc_dir = (idx_ext > pos_ext) ? DIR_UP : DIR_DOWN;
                  state_d = TRACK;
               end else begin
                  pos_d       = dec_idx;
                  pos_valid_d = 1'b1;
               end
            end
            TRACK: begin
               if (dec_valid && (idx_ext == exp_ext)) begin
                  accept  = 1'b1;
                  acc_dir = dir_q;
               end else begin
                  step_err_d  = 1'b1;
                  err_inc     = 1'b1;
                  state_d     = ACQUIRE;
                  pos_valid_d = dec_valid;
                  if (dec_valid) pos_d = dec_idx;
               end
            end
            default: state_d = ACQUIRE;
         endcase
      end

      if (accept) begin
         pos_d       = dec_idx;
         pos_valid_d = 1'b1;
         if (dec_idx == TOP_IDX) begin
            dir_d      = DIR_DOWN;
            bounce_inc = 1'b1;
         end else if (dec_idx == '0) begin
            dir_d      = DIR_UP;
            bounce_inc = 1'b1;
         end else begin
            dir_d = acc_dir;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACQUIRE;
         last_q      <= '0;
         pos_q       <= '0;
         pos_valid_q <= 1'b0;
         dir_q       <= DIR_DOWN;
         step_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         pos_q       <= pos_d;
         pos_valid_q <= pos_valid_d;
         dir_q       <= dir_d;
         step_err_q  <= step_err_d;
      end
   end

   // saturating counters; clear takes priority over a same-cycle increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bounce_q <= '0;
         err_q    <= '0;
      end else begin
         if (clear)                                bounce_q <= '0;
         else if (bounce_inc && (bounce_q != '1))  bounce_q <= bounce_q + CNT_ONE;
         if (clear)                                err_q    <= '0;
         else if (err_inc && (err_q != '1))        err_q    <= err_q + CNT_ONE;
      end
   end

   assign pos          = pos_q;
   assign pos_valid    = pos_valid_q;
   assign dir          = dir_q;
   assign locked       = (state_q == TRACK);
   assign step_err     = step_err_q;
   assign bounce_count = bounce_q;
   assign err_count    = err_q;

endmodule

// File: tb/tb_led_sweep_monitor.sv
// Scoreboard bench for led_sweep_monitor: behavioural model, random sweeps, directed corner cases.
module tb_led_sweep_monitor;

   localparam int N  = 8;
   localparam int PW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  led_in = '0;
   logic          clear = 1'b0;

   logic [PW-1:0] pos, s_pos;
   logic          pos_valid, dir, locked, step_err;
   logic          s_pos_valid, s_dir, s_locked, s_step_err;
   logic [15:0]   bounce_count, err_count;
   logic [1:0]    s_bounce, s_err;

   led_sweep_monitor #(.N(N), .CW(16)) dut (
      .clk(clk), .rst_n(rst_n), .led_in(led_in), .clear(clear),
      .pos(pos), .pos_valid(pos_valid), .dir(dir), .locked(locked),
      .step_err(step_err), .bounce_count(bounce_count), .err_count(err_count)
   );

   led_sweep_monitor #(.N(N), .CW(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .led_in(led_in), .clear(clear),
      .pos(s_pos), .pos_valid(s_pos_valid), .dir(s_dir), .locked(s_locked),
      .step_err(s_step_err), .bounce_count(s_bounce), .err_count(s_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int tag;
      int pos, pv, dir, locked, serr, bc, ec, bc2, ec2;
   } exp_t;
   exp_t sbq[$];

   int         m_pos, m_bc, m_ec, m_bc2, m_ec2;
   bit         m_pv, m_dir, m_locked;
   logic [7:0] m_last;

   function automatic void model_reset();
      m_pos = 0; m_pv = 0; m_dir = 0; m_locked = 0; m_last = '0;
      m_bc = 0; m_ec = 0; m_bc2 = 0; m_ec2 = 0;
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v < mx) ? v + 1 : mx;
   endfunction

   task automatic model_step(input logic [7:0] pat, input bit clr, output bit serr);
      int  ones, p, want;
      bit  acc, d, bump;
      serr = 0; acc = 0; d = 0; bump = 0;
      ones = $countones(pat);
      p = 0;
      for (int i = 0; i < N; i++) if (pat[i]) p = i;
      if (pat != m_last) begin
         m_last = pat;
         if (!m_locked) begin
            if (ones > 1) m_pv = 0;
            else if (ones == 1) begin
               if (m_pv && (p == m_pos + 1 || p == m_pos - 1)) begin
                  acc = 1; d = (p > m_pos); m_locked = 1;
               end else begin
                  m_pos = p; m_pv = 1;
               end
            end
         end else begin
            want = m_dir ? m_pos + 1 : m_pos - 1;
            if (ones == 1 && p == want) begin
               acc = 1; d = m_dir;
            end else begin
               serr = 1; m_locked = 0;
               if (ones == 1) begin m_pos = p; m_pv = 1; end
               else m_pv = 0;
            end
         end
      end
      if (acc) begin
         m_pos = p; m_pv = 1;
         if (p == N - 1)  begin m_dir = 0; bump = 1; end
         else if (p == 0) begin m_dir = 1; bump = 1; end
         else m_dir = d;
      end
      if (clr) begin
         m_bc = 0; m_ec = 0; m_bc2 = 0; m_ec2 = 0;
      end else begin
         if (bump) begin m_bc = sat(m_bc, 65535); m_bc2 = sat(m_bc2, 3); end
         if (serr) begin m_ec = sat(m_ec, 65535); m_ec2 = sat(m_ec2, 3); end
      end
   endtask

   // called at posedge+1; returns at posedge+1 of the edge that sampled pat
   task automatic drive(input logic [7:0] pat, input bit clr);
      exp_t e;
      bit   serr;
      led_in = pat;
      clear  = clr;
      model_step(pat, clr, serr);
      e.tag = cyc + 1;
      e.pos = m_pos; e.pv = m_pv; e.dir = m_dir; e.locked = m_locked; e.serr = serr;
      e.bc = m_bc; e.ec = m_ec; e.bc2 = m_bc2; e.ec2 = m_ec2;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
         e = sbq.pop_front();
         chk("pos",        pos,          e.pos);
         chk("pos_valid",  pos_valid,    e.pv);
         chk("dir",        dir,          e.dir);
         chk("locked",     locked,       e.locked);
         chk("step_err",   step_err,     e.serr);
         chk("bounce",     bounce_count, e.bc);
         chk("err",        err_count,    e.ec);
         chk("bounce_cw2", s_bounce,     e.bc2);
         chk("err_cw2",    s_err,        e.ec2);
      end
   end

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_pos"},       pos,          0);
      chk({nm, "_pos_valid"}, pos_valid,    0);
      chk({nm, "_dir"},       dir,          0);
      chk({nm, "_locked"},    locked,       0);
      chk({nm, "_step_err"},  step_err,     0);
      chk({nm, "_bounce"},    bounce_count, 0);
      chk({nm, "_err"},       err_count,    0);
      chk({nm, "_err_cw2"},   s_err,        0);
   endtask

   // asynchronous reset asserted between edges, held over one edge, released away from it
   task automatic do_reset();
      #6;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      led_in = 8'($urandom_range(255));
      @(posedge clk);
      #1;
      chk_reset_vals("held_rst");
      led_in = '0;
      model_reset();
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pat;
      int r, p;
      model_reset();
      @(posedge clk);
      #1;
      chk_reset_vals("por");
      rst_n = 1'b1;

      // basic acquisition
      drive(8'h01, 0); drive(8'h02, 0);
      chk("t1_locked", locked, 1); chk("t1_pos", pos, 1);
      chk("t1_dir", dir, 1);       chk("t1_bounce", bounce_count, 0);
      drive(8'h04, 0);
      chk("t1_pos2", pos, 2);

      // full sweep with acquisition landing on index 0
      do_reset();
      drive(8'h02, 0); drive(8'h01, 0);
      for (int i = 1; i < N; i++) drive(8'd1 << i, 0);
      chk("t2_top_dir", dir, 0); chk("t2_top_bounce", bounce_count, 2);
      for (int i = N - 2; i >= 0; i--) drive(8'd1 << i, 0);
      chk("t2_end_dir", dir, 1); chk("t2_end_bounce", bounce_count, 3);
      chk("t2_err", err_count, 0);

      // hold then skipped step
      do_reset();
      drive(8'h04, 0); drive(8'h08, 0);
      for (int i = 0; i < 5; i++) drive(8'h08, 0);
      chk("t3_hold_err", err_count, 0);
      drive(8'h20, 0);
      chk("t3_serr", step_err, 1); chk("t3_err", err_count, 1);
      chk("t3_locked", locked, 0); chk("t3_pos", pos, 5);
      drive(8'h20, 0);
      chk("t3_serr_pulse", step_err, 0);

      // multi-hot violation and re-acquisition
      drive(8'h40, 0);
      chk("t4_relock", locked, 1);
      drive(8'h11, 0);
      chk("t4_serr", step_err, 1); chk("t4_pv", pos_valid, 0);
      drive(8'h01, 0);
      chk("t4_pv1", pos_valid, 1); chk("t4_unlocked", locked, 0);
      drive(8'h02, 0);
      chk("t4_locked", locked, 1); chk("t4_pos", pos, 1);

      // CW=2 saturation, then clear racing a violation
      do_reset();
      drive(8'h01, 0); drive(8'h02, 0);
      drive(8'h08, 0); chk("t5_e1", s_err, 1); drive(8'h10, 0);
      drive(8'h04, 0); chk("t5_e2", s_err, 2); drive(8'h08, 0);
      drive(8'h20, 0); chk("t5_e3", s_err, 3); drive(8'h40, 0);
      drive(8'h10, 0); chk("t5_e4", s_err, 3); drive(8'h20, 0);
      drive(8'h01, 1);
      chk("t5_clr", s_err, 0); chk("t5_clr_serr", s_step_err, 1);

      // reset mid-sweep, re-acquire needs two adjacent patterns
      do_reset();
      drive(8'h01, 0); drive(8'h02, 0); drive(8'h04, 0);
      do_reset();
      drive(8'h08, 0); chk("t6_one", locked, 0);
      drive(8'h08, 0); chk("t6_hold", locked, 0);
      drive(8'h10, 0); chk("t6_two", locked, 1);

      // randomized traffic
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(99);
         if (r < 60) begin
            if (m_locked) p = m_dir ? m_pos + 1 : m_pos - 1;
            else if (m_pv) begin
               if (m_pos == 0) p = 1;
               else if (m_pos == N - 1) p = N - 2;
               else p = ($urandom_range(1) == 1) ? m_pos + 1 : m_pos - 1;
            end else p = $urandom_range(N - 1);
            pat = 8'd1 << p;
         end else if (r < 75) pat = led_in;
         else if (r < 88)     pat = 8'd1 << $urandom_range(N - 1);
         else if (r < 96)     pat = 8'($urandom_range(255));
         else                 pat = '0;
         drive(pat, $urandom_range(49) == 0);
         if ($urandom_range(599) == 0) do_reset();
      end

      #10;
      chk("sb_drained", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
